// File: rtl/temperature.sv
// Thermostat controller: a cooler and a heater with hysteresis, a level-sensitive off switch,
// and an asynchronous active-high reset. Both outputs are combinational from temp.
//
// state   | meaning
// IDLE    | neither output active, no hysteresis held
// COOLING | cooler was on at the last edge; holds it on while temp > COOL_OFF
// HEATING | heater was on at the last edge; holds it on while temp < HEAT_OFF
// OFF     | off_btn held; acts like IDLE once released
module temperature #(
    parameter int COOL_ON  = 35,
    parameter int COOL_OFF = 25,
    parameter int HEAT_ON  = 15,
    parameter int HEAT_OFF = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               off_btn,
    input  logic signed [31:0] temp,
    output logic               cooler,
    output logic               heater
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOLING = 2'd1,
        HEATING = 2'd2,
        OFF     = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   enable;

    assign enable = !reset && !off_btn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Parameter ordering keeps the cooler and heater conditions mutually exclusive.
    always_comb begin
        cooler     = 1'b0;
        heater     = 1'b0;
        state_next = IDLE;

        if (enable) begin
            cooler = (temp >= COOL_ON) || ((state == COOLING) && (temp > COOL_OFF));
            heater = (temp <= HEAT_ON) || ((state == HEATING) && (temp < HEAT_OFF));
        end

        if (off_btn) begin
            state_next = OFF;
        end else if (cooler) begin
            state_next = COOLING;
        end else if (heater) begin
            state_next = HEATING;
        end else begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_temperature.sv
// Bench for the thermostat: hand-written vector table, directed reset sequences,
// and randomized stimulus against a model where hysteresis is "last output was on".
module tb_temperature;

    localparam int C_ON  = 35;
    localparam int C_OFF = 25;
    localparam int H_ON  = 15;
    localparam int H_OFF = 20;

    logic               clock;
    logic               reset;
    logic               off_btn;
    logic signed [31:0] temp;
    logic               cooler;
    logic               heater;

    int n_cmp = 0;
    int n_bad = 0;

    // Model memory: what each output was when the last clock edge sampled it.
    logic lc = 1'b0;
    logic lh = 1'b0;
    logic mc;
    logic mh;

    typedef struct {
        logic off;
        int   t;
        logic c;
        logic h;
    } vec_t;

    vec_t tbl[$];

    temperature #(
        .COOL_ON (C_ON),
        .COOL_OFF(C_OFF),
        .HEAT_ON (H_ON),
        .HEAT_OFF(H_OFF)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .off_btn(off_btn),
        .temp   (temp),
        .cooler (cooler),
        .heater (heater)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Drive inputs away from the rising edge, compute the model outputs, and
    // remember them as the hysteresis the next edge will latch.
    task automatic drive(input logic r, input logic o, input int t);
        @(negedge clock);
        reset   = r;
        off_btn = o;
        temp    = t;
        #1;
        if (r || o) begin
            mc = 1'b0;
            mh = 1'b0;
        end else begin
            mc = (t >= C_ON) || (lc && t > C_OFF);
            mh = (t <= H_ON) || (lh && t < H_OFF);
        end
        lc = mc;
        lh = mh;
    endtask

    task automatic step_model(input logic r, input logic o, input int t, input string nm);
        drive(r, o, t);
        chk({nm, ".cooler"}, cooler, mc);
        chk({nm, ".heater"}, heater, mh);
    endtask

    initial begin
        reset   = 1'b1;
        off_btn = 1'b0;
        temp    = 100;
        #1;
        chk("reset.cooler", cooler, 1'b0);
        chk("reset.heater", heater, 1'b0);
        #29;

        tbl.push_back('{1'b0,  100, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  100, 1'b1, 1'b0});
        tbl.push_back('{1'b0,   30, 1'b1, 1'b0});
        tbl.push_back('{1'b0,   25, 1'b0, 1'b0});
        tbl.push_back('{1'b0,   30, 1'b0, 1'b0});
        tbl.push_back('{1'b0,   35, 1'b1, 1'b0});
        tbl.push_back('{1'b0,    9, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   18, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   20, 1'b0, 1'b0});
        tbl.push_back('{1'b0,  -40, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   16, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   35, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  100, 1'b1, 1'b0});
        tbl.push_back('{1'b1,  100, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  100, 1'b0, 1'b0});
        tbl.push_back('{1'b0,  100, 1'b1, 1'b0});
        tbl.push_back('{1'b1,  100, 1'b0, 1'b0});
        tbl.push_back('{1'b0,   30, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  -40, 1'b0, 1'b0});
        tbl.push_back('{1'b0,   18, 1'b0, 1'b0});
        tbl.push_back('{1'b0,   15, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   19, 1'b0, 1'b1});
        tbl.push_back('{1'b0,   20, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].off, tbl[i].t);
            chk($sformatf("vec%0d.cooler", i), cooler, tbl[i].c);
            chk($sformatf("vec%0d.heater", i), heater, tbl[i].h);
        end

        // Dead band from IDLE: nothing turns on between the two on-thresholds.
        for (int t = 16; t <= 34; t++) begin
            drive(1'b0, 1'b0, t);
            chk($sformatf("sweep%0d.cooler", t), cooler, 1'b0);
            chk($sformatf("sweep%0d.heater", t), heater, 1'b0);
        end
        drive(1'b0, 1'b0, -40);
        chk("neg40.heater", heater, 1'b1);
        chk("neg40.cooler", cooler, 1'b0);

        // Reset between edges while heating drops the heater immediately.
        drive(1'b0, 1'b0, 9);
        chk("preheat.heater", heater, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        lc = 1'b0;
        lh = 1'b0;
        #1;
        chk("asyncrst_heat.heater", heater, 1'b0);
        @(posedge clock);
        #1;
        chk("rsthold.heater", heater, 1'b0);
        drive(1'b0, 1'b0, 18);
        chk("rstrel18.heater", heater, 1'b0);
        chk("rstrel18.cooler", cooler, 1'b0);

        // Same for cooling.
        drive(1'b0, 1'b0, 100);
        @(posedge clock);
        #3;
        reset = 1'b1;
        lc = 1'b0;
        lh = 1'b0;
        #1;
        chk("asyncrst_cool.cooler", cooler, 1'b0);
        drive(1'b0, 1'b0, 30);
        chk("rstrel30.cooler", cooler, 1'b0);

        for (int i = 0; i < 600; i++) begin
            int  t;
            logic r;
            logic o;
            if ($urandom_range(0, 9) == 0)
                t = $urandom_range(0, 1) ? C_ON : ($urandom_range(0, 1) ? C_OFF :
                    ($urandom_range(0, 1) ? H_ON : H_OFF));
            else
                t = int'($urandom_range(0, 80)) - 30;
            r = ($urandom_range(0, 39) == 0);
            o = ($urandom_range(0, 9) == 0);
            step_model(r, o, t, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d.excl", i), cooler & heater, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
